// File: rtl/block_xfer_sequencer.sv
// Block-transfer sequencer: expands LDM/STM into one memory micro-op per listed register.
// Non-block instructions pass through as a single micro-op.
module block_xfer_sequencer #(
    parameter int REG_CNT    = 16,
    parameter int WORD_BYTES = 4,
    parameter int OFFSET_W   = 8
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                InstrValid,
    input  logic [31:0]         Instr,
    output logic                InstrReady,
    input  logic                Flush,
    input  logic                Stall,
    output logic                UopValid,
    output logic [31:0]         UopInstr,
    output logic                UopBlk,
    output logic                UopL,
    output logic [3:0]          UopReg,
    output logic [OFFSET_W-1:0] UopOffset,
    output logic                UopLast,
    output logic                UopWBack,
    output logic [OFFSET_W-1:0] UopWBOffset,
    output logic                Busy
);

    typedef enum logic [0:0] {IDLE, SEQ} state_e;

    localparam logic [OFFSET_W-1:0] WB  = OFFSET_W'(WORD_BYTES);
    localparam logic [REG_CNT-1:0]  ONE = REG_CNT'(1);

    function automatic logic [OFFSET_W-1:0] popcnt(input logic [REG_CNT-1:0] v);
        logic [OFFSET_W-1:0] c;
        c = '0;
        for (int i = 0; i < REG_CNT; i++) c = c + OFFSET_W'(v[i]);
        return c;
    endfunction

    function automatic logic [3:0] lowest(input logic [REG_CNT-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = REG_CNT - 1; i >= 0; i--) if (v[i]) idx = 4'(i);
        return idx;
    endfunction

    state_e              state_q, state_d;
    logic [REG_CNT-1:0]  mask_q, mask_d;
    logic                uop_valid_q, uop_valid_d;
    logic [31:0]         uop_instr_q, uop_instr_d;
    logic                uop_blk_q, uop_blk_d;
    logic                uop_l_q, uop_l_d;
    logic [3:0]          uop_reg_q, uop_reg_d;
    logic [OFFSET_W-1:0] uop_offset_q, uop_offset_d;
    logic                uop_last_q, uop_last_d;
    logic                uop_wback_q, uop_wback_d;
    logic [OFFSET_W-1:0] uop_wboffset_q, uop_wboffset_d;

    logic                fire, accept, ready, is_blk, seq_last;
    logic [REG_CNT-1:0]  list, seq_rest;
    logic [OFFSET_W-1:0] cnt, nwb, base;

    always_comb begin
        fire     = uop_valid_q & ~Stall;
        ready    = RESETn & (state_q == IDLE) & (~uop_valid_q | ~Stall) & ~Flush;
        accept   = InstrValid & ready;
        list     = Instr[REG_CNT-1:0];
        is_blk   = (Instr[27:25] == 3'b100);
        cnt      = popcnt(list);
        nwb      = cnt * WB;
        seq_rest = mask_q & (mask_q - ONE);
        seq_last = (seq_rest == '0);
        // Offset of the lowest register for each IA/IB/DA/DB addressing mode
        base = '0;
        unique case ({Instr[24], Instr[23]})
            2'b01: base = '0;
            2'b11: base = WB;
            2'b00: base = WB - nwb;
            2'b10: base = '0 - nwb;
        endcase

        state_d        = state_q;
        mask_d         = mask_q;
        uop_valid_d    = uop_valid_q;
        uop_instr_d    = uop_instr_q;
        uop_blk_d      = uop_blk_q;
        uop_l_d        = uop_l_q;
        uop_reg_d      = uop_reg_q;
        uop_offset_d   = uop_offset_q;
        uop_last_d     = uop_last_q;
        uop_wback_d    = uop_wback_q;
        uop_wboffset_d = uop_wboffset_q;

        if (Flush) begin
            state_d     = IDLE;
            mask_d      = '0;
            uop_valid_d = 1'b0;
        end else if (accept) begin
            uop_instr_d = Instr;
            if (!is_blk) begin
                uop_valid_d    = 1'b1;
                uop_blk_d      = 1'b0;
                uop_l_d        = 1'b0;
                uop_reg_d      = Instr[15:12];
                uop_offset_d   = '0;
                uop_last_d     = 1'b1;
                uop_wback_d    = 1'b0;
                uop_wboffset_d = '0;
            end else if (list == '0) begin
                uop_valid_d = 1'b0;
            end else begin
                uop_valid_d    = 1'b1;
                uop_blk_d      = 1'b1;
                uop_l_d        = Instr[20];
                uop_reg_d      = lowest(list);
                uop_offset_d   = base;
                uop_last_d     = (cnt == OFFSET_W'(1));
                uop_wback_d    = Instr[21] & (cnt == OFFSET_W'(1));
                uop_wboffset_d = Instr[23] ? nwb : ('0 - nwb);
                mask_d         = list & (list - ONE);
                state_d        = (cnt == OFFSET_W'(1)) ? IDLE : SEQ;
            end
        end else if (state_q == SEQ && fire) begin
            uop_reg_d    = lowest(mask_q);
            uop_offset_d = uop_offset_q + WB;
            uop_last_d   = seq_last;
            uop_wback_d  = uop_instr_q[21] & seq_last;
            mask_d       = seq_rest;
            state_d      = seq_last ? IDLE : SEQ;
        end else if (fire) begin
            uop_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            uop_valid_q    <= 1'b0;
            uop_instr_q    <= '0;
            uop_blk_q      <= 1'b0;
            uop_l_q        <= 1'b0;
            uop_reg_q      <= '0;
            uop_offset_q   <= '0;
            uop_last_q     <= 1'b0;
            uop_wback_q    <= 1'b0;
            uop_wboffset_q <= '0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            uop_valid_q    <= uop_valid_d;
            uop_instr_q    <= uop_instr_d;
            uop_blk_q      <= uop_blk_d;
            uop_l_q        <= uop_l_d;
            uop_reg_q      <= uop_reg_d;
            uop_offset_q   <= uop_offset_d;
            uop_last_q     <= uop_last_d;
            uop_wback_q    <= uop_wback_d;
            uop_wboffset_q <= uop_wboffset_d;
        end
    end

    assign InstrReady  = ready;
    assign UopValid    = uop_valid_q;
    assign UopInstr    = uop_instr_q;
    assign UopBlk      = uop_blk_q;
    assign UopL        = uop_l_q;
    assign UopReg      = uop_reg_q;
    assign UopOffset   = uop_offset_q;
    assign UopLast     = uop_last_q;
    assign UopWBack    = uop_wback_q;
    assign UopWBOffset = uop_wboffset_q;
    assign Busy        = (state_q == SEQ);

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// Bench for block_xfer_sequencer: directed steps with a queue of expected micro-ops.
// Expected micro-ops are popped whenever one fires downstream.
module tb_block_xfer_sequencer;

    logic        CLK;
    logic        RESETn;
    logic        InstrValid;
    logic [31:0] Instr;
    logic        InstrReady;
    logic        Flush;
    logic        Stall;
    logic        UopValid;
    logic [31:0] UopInstr;
    logic        UopBlk;
    logic        UopL;
    logic [3:0]  UopReg;
    logic [7:0]  UopOffset;
    logic        UopLast;
    logic        UopWBack;
    logic [7:0]  UopWBOffset;
    logic        Busy;

    block_xfer_sequencer dut (
        .CLK(CLK), .RESETn(RESETn), .InstrValid(InstrValid), .Instr(Instr),
        .InstrReady(InstrReady), .Flush(Flush), .Stall(Stall),
        .UopValid(UopValid), .UopInstr(UopInstr), .UopBlk(UopBlk), .UopL(UopL),
        .UopReg(UopReg), .UopOffset(UopOffset), .UopLast(UopLast),
        .UopWBack(UopWBack), .UopWBOffset(UopWBOffset), .Busy(Busy)
    );

    typedef struct {
        logic [31:0] instr;
        logic        blk;
        logic        l;
        logic [3:0]  rg;
        logic [7:0]  off;
        logic        last;
        logic        wback;
        logic [7:0]  wbo;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] ADD_R1   = 32'hE0821003;
    localparam logic [31:0] LDMIA_W  = 32'hE8B00092;
    localparam logic [31:0] STMDB_SP = 32'hE92D40F0;
    localparam logic [31:0] LDMIB_R3 = 32'hE9930224;
    localparam logic [31:0] LDMIA_4  = 32'hE891000F;
    localparam logic [31:0] LDM_EMPTY = 32'hE8900000;
    localparam logic [31:0] LDMDA_4  = 32'hE810000F;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [31:0] ins);
        exp_t e;
        int n, base, k;
        e.instr = ins;
        if (ins[27:25] != 3'b100) begin
            e.blk = 0; e.l = 0; e.rg = ins[15:12]; e.off = 0;
            e.last = 1; e.wback = 0; e.wbo = 0;
            q.push_back(e);
            return;
        end
        n = 0;
        for (int i = 0; i < 16; i++) if (ins[i]) n++;
        if (n == 0) return;
        case ({ins[24], ins[23]})
            2'b01:   base = 0;
            2'b11:   base = 4;
            2'b00:   base = -(n - 1) * 4;
            default: base = -n * 4;
        endcase
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (ins[i]) begin
                e.blk   = 1;
                e.l     = ins[20];
                e.rg    = 4'(i);
                e.off   = 8'(base + k * 4);
                e.last  = (k == n - 1);
                e.wback = ins[21] && (k == n - 1);
                e.wbo   = ins[23] ? 8'(n * 4) : 8'(-(n * 4));
                q.push_back(e);
                k++;
            end
        end
    endtask

    // Scoreboard: compare every micro-op that downstream actually takes
    always @(negedge CLK) begin
        if (RESETn && UopValid && !Stall && !Flush) begin
            if (q.size() == 0) begin
                check("unexpected_uop", 32'(UopReg), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("uop_instr", UopInstr, e.instr);
                check("uop_blk", 32'(UopBlk), 32'(e.blk));
                check("uop_l", 32'(UopL), 32'(e.l));
                check("uop_reg", 32'(UopReg), 32'(e.rg));
                check("uop_offset", 32'(UopOffset), 32'(e.off));
                check("uop_last", 32'(UopLast), 32'(e.last));
                check("uop_wback", 32'(UopWBack), 32'(e.wback));
                if (e.last) check("uop_wboffset", 32'(UopWBOffset), 32'(e.wbo));
            end
        end
    end

    task automatic send(input logic [31:0] ins, output int waited);
        int t;
        Instr = ins;
        InstrValid = 1'b1;
        push_model(ins);
        t = 0;
        @(negedge CLK);
        while (!InstrReady && t < 50) begin
            @(negedge CLK);
            t++;
        end
        check("send_timeout", 32'(t < 50), 32'd1);
        @(posedge CLK);
        #1;
        InstrValid = 1'b0;
        Instr = '0;
        waited = t;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((q.size() != 0 || UopValid) && t < 60) begin
            @(posedge CLK);
            #1;
            t++;
        end
        check(tag, 32'(t < 60), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        RESETn = 0; InstrValid = 0; Instr = '0; Flush = 0; Stall = 0;
        @(posedge CLK);
        #1;
        check("rst_valid", 32'(UopValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ready", 32'(InstrReady), 32'd0);
        check("rst_offset", 32'(UopOffset), 32'd0);
        @(negedge CLK);
        RESETn = 1;
        @(posedge CLK);
        #1;
        check("idle_ready", 32'(InstrReady), 32'd1);

        // Plain ALU instruction
        send(ADD_R1, w);
        check("add_valid", 32'(UopValid), 32'd1);
        check("add_last", 32'(UopLast), 32'd1);
        check("add_ready", 32'(InstrReady), 32'd1);
        drain("drain_add");

        // LDMIA then STMDB back-to-back
        send(LDMIA_W, w);
        check("ldmia_busy", 32'(Busy), 32'd1);
        send(STMDB_SP, w);
        check("b2b_wait", 32'(w), 32'd2);
        drain("drain_ldm_stm");
        check("stm_idle", 32'(Busy), 32'd0);

        // LDMIB with the second micro-op held by Stall
        send(LDMIB_R3, w);
        @(posedge CLK);
        #1;
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("stall_valid", 32'(UopValid), 32'd1);
            check("stall_reg", 32'(UopReg), 32'd5);
            check("stall_off", 32'(UopOffset), 32'd8);
            check("stall_busy", 32'(Busy), 32'd1);
        end
        Stall = 0;
        drain("drain_ldmib");
        check("ldmib_idle", 32'(Busy), 32'd0);

        // Flush on the second micro-op of a 4-register LDM
        send(LDMIA_4, w);
        @(posedge CLK);
        #1;
        check("pre_flush_busy", 32'(Busy), 32'd1);
        Flush = 1;
        InstrValid = 1;
        Instr = ADD_R1;
        #1;
        check("flush_ready", 32'(InstrReady), 32'd0);
        @(posedge CLK);
        #1;
        Flush = 0;
        InstrValid = 0;
        q.delete();
        check("flush_valid", 32'(UopValid), 32'd0);
        check("flush_busy", 32'(Busy), 32'd0);
        send(ADD_R1, w);
        check("post_flush_wait", 32'(w), 32'd0);
        drain("drain_flush");

        // Empty list is swallowed
        send(LDM_EMPTY, w);
        check("empty_valid", 32'(UopValid), 32'd0);
        @(posedge CLK);
        #1;
        check("empty_valid2", 32'(UopValid), 32'd0);
        check("empty_busy", 32'(Busy), 32'd0);

        // Asynchronous reset in the middle of LDMDA
        send(LDMDA_4, w);
        @(posedge CLK);
        #2;
        check("lda_busy", 32'(Busy), 32'd1);
        RESETn = 0;
        #1;
        q.delete();
        check("arst_valid", 32'(UopValid), 32'd0);
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_ready", 32'(InstrReady), 32'd0);
        check("arst_reg", 32'(UopReg), 32'd0);
        check("arst_off", 32'(UopOffset), 32'd0);
        check("arst_instr", UopInstr, 32'd0);
        check("arst_blk", 32'(UopBlk), 32'd0);
        check("arst_last", 32'(UopLast), 32'd0);
        check("arst_wbo", 32'(UopWBOffset), 32'd0);
        @(negedge CLK);
        RESETn = 1;
        @(posedge CLK);
        #1;
        check("rel_ready", 32'(InstrReady), 32'd1);
        check("rel_valid", 32'(UopValid), 32'd0);
        send(ADD_R1, w);
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
